// File: rtl/s27_pkg.sv
// Shared types and the combinational s27 next-state function for s27_array.
package s27_pkg;

  // State bits held by one s27 channel.
  localparam int S27_SW = 3;

  // One channel's state; g5 sits first on the scan chain, g7 last.
  typedef struct packed {
    logic g5;
    logic g6;
    logic g7;
  } s27_state_t;

  // Next state together with the combinational G17 value.
  typedef struct packed {
    s27_state_t nxt;
    logic       g17c;
  } s27_result_t;

  // What a channel does on the coming clock edge, highest priority first.
  typedef enum logic [1:0] {
    OP_RESET,
    OP_SHIFT,
    OP_FUNC,
    OP_HOLD
  } s27_op_t;

  // Original s27 gate network: current state plus inputs give next state and G17.
  function automatic s27_result_t s27_next(input s27_state_t st,
                                           input logic g0,
                                           input logic g1,
                                           input logic g2,
                                           input logic g3);
    logic n13;
    logic n15;
    logic n16;
    logic n17;
    logic g11;
    s27_result_t r;
    n13        = ~st.g6;
    n17        = ~g0 & st.g6;
    n16        = ~(n17 | g3);
    n15        = (g0 | n13) & (st.g7 | g1);
    g11        = ~(st.g5 | n15 | n16);
    r.g17c     = ~g11;
    r.nxt.g5   = r.g17c & g0;
    r.nxt.g6   = g11;
    r.nxt.g7   = ~g2 & (g1 | st.g7);
    return r;
  endfunction

endpackage

// File: rtl/s27_array_core.sv
// One s27 channel: state register with scan, G17 output path and a
// saturating counter of G17 rising edges.
module s27_core
  import s27_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             se,
  input  logic             si,
  input  logic             cnt_clr,
  input  logic             g0,
  input  logic             g1,
  input  logic             g2,
  input  logic             g3,
  output logic             so,
  output logic             g17,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  s27_state_t  state_q;
  s27_result_t res;
  s27_op_t     op;
  logic        g17_q;
  logic        rise;

  assign res = s27_next(state_q, g0, g1, g2, g3);

  // Resolve the control inputs into one operation: reset, then scan, then enable.
  always_comb begin
    op = OP_HOLD;
    if (rst) begin
      op = OP_RESET;
    end else if (se) begin
      op = OP_SHIFT;
    end else if (en) begin
      op = OP_FUNC;
    end
  end

  // Channel state: cleared, shifted one place along the chain, or loaded functionally.
  always_ff @(posedge ck) begin
    unique case (op)
      OP_RESET: state_q <= '0;
      OP_SHIFT: state_q <= '{g5: si, g6: state_q.g5, g7: state_q.g6};
      OP_FUNC:  state_q <= res.nxt;
      default:  state_q <= state_q;
    endcase
  end

  // Previous G17 value; it is also the registered G17 output since both load identically.
  always_ff @(posedge ck) begin
    if (op == OP_RESET) begin
      g17_q <= 1'b1;
    end else if (op == OP_FUNC) begin
      g17_q <= res.g17c;
    end
  end

  assign rise = (op == OP_FUNC) && res.g17c && !g17_q;

  // Edge counter: clear beats an increment, and it sticks at all ones.
  always_ff @(posedge ck) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (rise && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign so  = state_q.g7;
  assign g17 = (REG_OUT != 0) ? g17_q : res.g17c;

endmodule

// File: rtl/s27_array.sv
// NCH independent s27 channels on one clock, joined into a single scan chain.
module s27_array
  import s27_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 0
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 SE,
  input  logic                 SI,
  output logic                 SO,
  input  logic [NCH-1:0]       G0,
  input  logic [NCH-1:0]       G1,
  input  logic [NCH-1:0]       G2,
  input  logic [NCH-1:0]       G3,
  input  logic                 CNT_CLR,
  output logic [NCH-1:0]       G17,
  output logic [NCH*CNT_W-1:0] EDGE_CNT
);

  // scan[c] feeds channel c; scan[NCH] is the last channel's G7.
  logic [NCH:0] scan;

  assign scan[0] = SI;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    s27_core #(
      .CNT_W   (CNT_W),
      .REG_OUT (REG_OUT)
    ) u_core (
      .ck      (CK),
      .rst     (RST),
      .en      (EN),
      .se      (SE),
      .si      (scan[c]),
      .cnt_clr (CNT_CLR),
      .g0      (G0[c]),
      .g1      (G1[c]),
      .g2      (G2[c]),
      .g3      (G3[c]),
      .so      (scan[c+1]),
      .g17     (G17[c]),
      .cnt     (EDGE_CNT[c*CNT_W +: CNT_W])
    );
  end

  assign SO = scan[NCH];

endmodule

// File: tb/tb_s27_array.sv
// Bench for s27_array: a Mealy and a registered-output instance share all inputs.
module tb_s27_array;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic                 CK = 1'b0;
  logic                 RST;
  logic                 EN;
  logic                 SE;
  logic                 SI;
  logic                 CNT_CLR;
  logic [NCH-1:0]       G0;
  logic [NCH-1:0]       G1;
  logic [NCH-1:0]       G2;
  logic [NCH-1:0]       G3;
  logic                 soComb;
  logic                 soReg;
  logic [NCH-1:0]       g17Comb;
  logic [NCH-1:0]       g17Reg;
  logic [NCH*CNT_W-1:0] cntComb;
  logic [NCH*CNT_W-1:0] cntReg;

  int errors = 0;
  int checks = 0;

  // Free-running clock.
  always #5 CK = ~CK;

  s27_array #(.NCH(NCH), .CNT_W(CNT_W), .REG_OUT(0)) dutComb (
    .CK(CK), .RST(RST), .EN(EN), .SE(SE), .SI(SI), .SO(soComb),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3), .CNT_CLR(CNT_CLR),
    .G17(g17Comb), .EDGE_CNT(cntComb)
  );

  s27_array #(.NCH(NCH), .CNT_W(CNT_W), .REG_OUT(1)) dutReg (
    .CK(CK), .RST(RST), .EN(EN), .SE(SE), .SI(SI), .SO(soReg),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3), .CNT_CLR(CNT_CLR),
    .G17(g17Reg), .EDGE_CNT(cntReg)
  );

  // Channel-0 inputs {G0,G1,G2,G3}; expected comb G17 before the edge, counter and registered G17 after.
  typedef struct {
    logic [3:0] g;
    logic       en;
    logic       clr;
    logic       expComb;
    logic [7:0] expCnt;
    logic       expReg;
  } vec_t;

  localparam logic [3:0] PAT_A  = 4'b0001;
  localparam logic [3:0] PAT_B  = 4'b1100;
  localparam logic [3:0] PAT_A2 = 4'b0011;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setCh0(input logic [3:0] g);
    G0 = {{(NCH-1){1'b0}}, g[3]};
    G1 = {{(NCH-1){1'b0}}, g[2]};
    G2 = {{(NCH-1){1'b0}}, g[1]};
    G3 = {{(NCH-1){1'b0}}, g[0]};
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic resetAll();
    @(negedge CK);
    RST = 1'b1; EN = 1'b0; SE = 1'b0; SI = 1'b0; CNT_CLR = 1'b0;
    setCh0(4'b0000);
    @(negedge CK);
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    setCh0(v.g);
    EN = v.en;
    CNT_CLR = v.clr;
    #1;
    checkOutput($sformatf("vec%0d g17 comb", idx), 32'(g17Comb), 32'({3'b111, v.expComb}));
    @(posedge CK);
    #1;
    checkOutput($sformatf("vec%0d edge_cnt", idx), cntComb, {24'h0, v.expCnt});
    checkOutput($sformatf("vec%0d g17 reg", idx), 32'(g17Reg), 32'({3'b111, v.expReg}));
    @(negedge CK);
    CNT_CLR = 1'b0;
  endtask

  // One functional cycle on channel 0, no checks.
  task automatic stepCh0(input logic [3:0] g, input logic clr);
    setCh0(g);
    EN = 1'b1;
    CNT_CLR = clr;
    @(posedge CK);
    @(negedge CK);
    CNT_CLR = 1'b0;
  endtask

  task automatic shiftBit(input logic b, input logic en);
    SI = b;
    EN = en;
    @(posedge CK);
    #1;
  endtask

  logic [11:0] pattern;

  initial begin
    vecs[0]  = '{g: 4'b0000, en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b1};
    vecs[1]  = '{g: PAT_A,   en: 1'b1, clr: 1'b0, expComb: 1'b0, expCnt: 8'd0, expReg: 1'b0};
    vecs[2]  = '{g: PAT_A,   en: 1'b1, clr: 1'b0, expComb: 1'b0, expCnt: 8'd0, expReg: 1'b0};
    vecs[3]  = '{g: PAT_B,   en: 1'b0, clr: 1'b0, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b0};
    vecs[4]  = '{g: 4'b1011, en: 1'b0, clr: 1'b0, expComb: 1'b0, expCnt: 8'd0, expReg: 1'b0};
    vecs[5]  = '{g: 4'b0110, en: 1'b0, clr: 1'b0, expComb: 1'b0, expCnt: 8'd0, expReg: 1'b0};
    vecs[6]  = '{g: PAT_B,   en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd1, expReg: 1'b1};
    vecs[7]  = '{g: PAT_A2,  en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd1, expReg: 1'b1};
    vecs[8]  = '{g: PAT_A2,  en: 1'b1, clr: 1'b0, expComb: 1'b0, expCnt: 8'd1, expReg: 1'b0};
    vecs[9]  = '{g: PAT_B,   en: 1'b1, clr: 1'b1, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b1};
    vecs[10] = '{g: PAT_A2,  en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b1};
    vecs[11] = '{g: 4'b1101, en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b1};
    vecs[12] = '{g: PAT_A2,  en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b1};
    vecs[13] = '{g: PAT_A,   en: 1'b1, clr: 1'b0, expComb: 1'b0, expCnt: 8'd0, expReg: 1'b0};
    vecs[14] = '{g: PAT_B,   en: 1'b1, clr: 1'b0, expComb: 1'b1, expCnt: 8'd1, expReg: 1'b1};
    vecs[15] = '{g: 4'b0000, en: 1'b0, clr: 1'b1, expComb: 1'b1, expCnt: 8'd0, expReg: 1'b1};

    RST = 1'b1; EN = 1'b0; SE = 1'b0; SI = 1'b0; CNT_CLR = 1'b0;
    setCh0(4'b0000);

    // Reset values, including the G1=0,G3=1 case of the Mealy output.
    resetAll();
    #1;
    checkOutput("reset g17 comb", 32'(g17Comb), 32'hF);
    checkOutput("reset g17 reg", 32'(g17Reg), 32'hF);
    checkOutput("reset edge_cnt", cntComb, 32'h0);
    checkOutput("reset so", 32'(soComb), 32'h0);
    G3 = 4'b0010;
    #1;
    checkOutput("reset g17 comb g3", 32'(g17Comb), 32'hD);
    G3 = 4'b0000;

    // Idle inputs keep every channel at 000.
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      checkOutput($sformatf("idle%0d g17", i), 32'(g17Comb), 32'hF);
      checkOutput($sformatf("idle%0d edge_cnt", i), cntComb, 32'h0);
    end
    @(negedge CK);

    // Directed functional vectors on channel 0.
    resetAll();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Counter saturation: each B, A2, A2 round produces exactly one G17 rising edge.
    resetAll();
    stepCh0(PAT_A, 1'b0);
    for (int n = 1; n <= 300; n++) begin
      stepCh0(PAT_B, 1'b0);
      stepCh0(PAT_A2, 1'b0);
      stepCh0(PAT_A2, 1'b0);
      if (n == 10 || n == 255 || n == 300) begin
        checkOutput($sformatf("sat n=%0d comb", n), cntComb, {24'h0, (n > 255) ? 8'd255 : 8'(n)});
        checkOutput($sformatf("sat n=%0d reg", n), cntReg, {24'h0, (n > 255) ? 8'd255 : 8'(n)});
      end
    end
    stepCh0(PAT_B, 1'b1);
    checkOutput("clear beats edge", cntComb, 32'h0);

    // Scan in 101100111000 with EN toggling; first bit reaches SO on shift 12.
    resetAll();
    setCh0(PAT_B);
    pattern = 12'b101100111000;
    SE = 1'b1;
    for (int k = 0; k < 12; k++) begin
      shiftBit(pattern[11-k], 1'(k));
      checkOutput($sformatf("scan in %0d so", k), 32'(soComb), 32'((k == 11) ? pattern[11] : 1'b0));
      @(negedge CK);
    end
    checkOutput("scan edge_cnt held", cntComb, 32'h0);
    checkOutput("scan g17 reg held", 32'(g17Reg), 32'hF);
    for (int j = 1; j < 12; j++) begin
      shiftBit(1'b0, 1'(j));
      checkOutput($sformatf("scan out %0d so", j), 32'(soComb), 32'(pattern[11-j]));
      @(negedge CK);
    end

    // Fill the chain with ones, then reset while still in scan mode.
    for (int k = 0; k < 12; k++) begin
      shiftBit(1'b1, 1'b0);
      @(negedge CK);
    end
    checkOutput("fill so", 32'(soReg), 32'h1);
    RST = 1'b1;
    @(posedge CK);
    #1;
    checkOutput("rst midscan so", 32'(soComb), 32'h0);
    @(negedge CK);
    RST = 1'b0;
    for (int k = 0; k < 12; k++) begin
      shiftBit(1'b0, 1'b0);
      checkOutput($sformatf("post rst %0d so", k), 32'(soComb), 32'h0);
      @(negedge CK);
    end
    SE = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
